// File: rtl/ext_mem_ctlr.sv
// External memory controller: turns CPU bus read/write requests into timed accesses on a
// single-port asynchronous SRAM. Every output is registered and the bus echo is zero when idle.
module ext_mem_ctlr #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_q,
  input  logic              write_q,
  input  logic              rw_halt,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              read_dn,
  output logic              write_dn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we
);

  // The wait counter is 4 bits and must never wrap.
  if (RD_WAIT > 15 || WR_WAIT > 15) begin : g_bad_wait
    $error("ext_mem_ctlr: RD_WAIT/WR_WAIT must be in 0..15");
  end

  typedef enum logic [2:0] {
    StWait,
    StReadSetAddr,
    StReadDataGet,
    StReadFinish,
    StWriteSetAddr,
    StWriteSetWe,
    StWriteFinish
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              read_dn_q, read_dn_d;
  logic              write_dn_q, write_dn_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_oe_q, mem_oe_d;
  logic              mem_we_q, mem_we_d;

  // Outputs are computed on the transition into a state, so they are visible during it.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    addr_out_d  = '0;
    data_out_d  = '0;
    read_dn_d   = 1'b0;
    write_dn_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_ce_d    = mem_ce_q;
    mem_oe_d    = mem_oe_q;
    mem_we_d    = mem_we_q;

    unique case (state_q)
      StWait: begin
        if (!rw_halt) begin
          if (write_q) begin
            addr_d      = addr_in;
            wdata_d     = data_in;
            mem_addr_d  = addr_in;
            mem_wdata_d = data_in;
            mem_ce_d    = 1'b1;
            mem_we_d    = 1'b0;
            state_d     = StWriteSetAddr;
          end else if (read_q) begin
            addr_d     = addr_in;
            mem_addr_d = addr_in;
            mem_ce_d   = 1'b1;
            mem_oe_d   = 1'b1;
            state_d    = StReadSetAddr;
          end
        end
      end

      StReadSetAddr: begin
        if (!rw_halt) begin
          cnt_d   = 4'(RD_WAIT);
          state_d = StReadDataGet;
        end
      end

      StReadDataGet: begin
        if (!rw_halt) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            read_dn_d  = 1'b1;
            data_out_d = mem_rdata;
            addr_out_d = addr_q;
            mem_ce_d   = 1'b0;
            mem_oe_d   = 1'b0;
            mem_addr_d = '0;
            state_d    = StReadFinish;
          end
        end
      end

      StReadFinish: begin
        if (!read_q) state_d = StWait;
      end

      StWriteSetAddr: begin
        if (!rw_halt) begin
          cnt_d    = 4'(WR_WAIT);
          mem_we_d = 1'b1;
          state_d  = StWriteSetWe;
        end
      end

      StWriteSetWe: begin
        if (!rw_halt) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            mem_we_d   = 1'b0;
            mem_ce_d   = 1'b0;
            write_dn_d = 1'b1;
            addr_out_d = addr_q;
            state_d    = StWriteFinish;
          end
        end
      end

      StWriteFinish: begin
        // Address/data were held through this first cycle for device hold time.
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (!write_q) state_d = StWait;
      end

      default: state_d = StWait;
    endcase

    // Abort: drop the device strobes and discard the transaction without a done pulse.
    if (rw_halt && (state_q inside {StReadSetAddr, StReadDataGet,
                                    StWriteSetAddr, StWriteSetWe})) begin
      state_d     = StWait;
      mem_ce_d    = 1'b0;
      mem_oe_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StWait;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      addr_out_q  <= '0;
      data_out_q  <= '0;
      read_dn_q   <= 1'b0;
      write_dn_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ce_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      read_dn_q   <= read_dn_d;
      write_dn_q  <= write_dn_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ce_q    <= mem_ce_d;
      mem_oe_q    <= mem_oe_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign addr_out  = addr_out_q;
  assign data_out  = data_out_q;
  assign read_dn   = read_dn_q;
  assign write_dn  = write_dn_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_ce    = mem_ce_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we    = mem_we_q;

endmodule

// File: doc/ext_mem_ctlr.md
Name: ext_mem_ctlr

Overview:
- External memory controller sitting directly downstream of the CPU block's external bus port.
- Consumes its `addr_out`/`data_out`/`read_q`/`write_q`/`rw_halt_out`. Returns `read_dn`/`write_dn` and read data over an OR-combined bus.
- Drives a single-port asynchronous SRAM-style device with programmable wait states.
- Sequences every access through the fixed MEM_CTLR state set.

Parameters:
- ADDR_W, 32, address width; equals `ADDR_SIZE`.
- DATA_W, 32, data width; equals `DATA_SIZE`.
- RD_WAIT, 1, extra read-strobe cycles (0..15).
- WR_WAIT, 1, extra write-enable cycles (0..15).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- addr_in  in  ADDR_W  request address from CPU block.
- data_in  in  DATA_W  write data from CPU block.
- read_q  in  1  read request, level.
- write_q  in  1  write request, level.
- rw_halt  in  1  abort/hold from CPU block.
- addr_out  out  ADDR_W  echoed address, valid with dn, else 0.
- data_out  out  DATA_W  read data, valid with `read_dn`, else 0.
- read_dn  out  1  read done, one-cycle pulse.
- write_dn  out  1  write done, one-cycle pulse.
- mem_addr  out  ADDR_W  device address.
- mem_wdata  out  DATA_W  device write data.
- mem_rdata  in  DATA_W  device read data.
- mem_ce  out  1  chip enable, active-high.
- mem_oe  out  1  output enable, active-high.
- mem_we  out  1  write enable, active-high.

Behaviour:
- Reset (`rst_in`=0, async): state=WAIT; all outputs, latches and counter forced to 0.
- All outputs are registered. `addr_out`/`data_out` must be exactly 0 whenever no dn is asserted, because the upstream bus is OR-combined.
- States: WAIT, READ_SET_ADDRESS, READ_DATA_GET, READ_FINISH, WRITE_SET_ADDRESS, WRITE_SET_WE, WRITE_FINISH.
- WAIT:
  - Leaves only if `rw_halt`=0.
  - `write_q`=1 → latch `addr_in`/`data_in` → WRITE_SET_ADDRESS.
  - Else `read_q`=1 → latch `addr_in` → READ_SET_ADDRESS.
  - If both are high, write wins.
- READ_SET_ADDRESS (1 cycle): `mem_addr`=latched address, `mem_ce`=1, `mem_oe`=1, counter←RD_WAIT → READ_DATA_GET.
- READ_DATA_GET:
  - Holds `ce`/`oe`.
  - While counter≠0, decrement.
  - At counter=0, register `mem_rdata` into `data_out`, latched address into `addr_out`, pulse `read_dn`; → READ_FINISH.
- READ_FINISH:
  - `read_dn` high only in the first cycle; `ce`/`oe` low.
  - `data_out`/`addr_out` zeroed after that cycle.
  - Stays until `read_q`=0, then → WAIT.
- Read latency: `read_dn` high in cycle RD_WAIT+3, counting cycle 0 as the WAIT cycle that sampled `read_q`.
- WRITE_SET_ADDRESS (1 cycle): `mem_addr`/`mem_wdata` driven, `mem_ce`=1, `mem_we`=0, counter←WR_WAIT → WRITE_SET_WE.
- WRITE_SET_WE:
  - `mem_we`=1 for WR_WAIT+1 cycles (counter decrement).
  - At counter=0, `mem_we` drops next cycle, `write_dn` pulses, `addr_out`=address → WRITE_FINISH.
- WRITE_FINISH:
  - `mem_addr`/`mem_wdata` held one further cycle (hold time), then zeroed.
  - Stays until `write_q`=0, then → WAIT.
- Write latency: `write_dn` in cycle WR_WAIT+3.
- `rw_halt`=1 in any SET/GET/WE state:
  - Next cycle → WAIT.
  - `ce`/`oe`/`we` cleared.
  - No dn issued; the transaction is discarded.
- `rw_halt` in FINISH states has no effect.
- A request dropped mid-transaction (without `rw_halt`) is completed; dn still pulses once.
- Back-to-back: a request held high after FINISH is not reissued; it must go low for at least one cycle.
- Counter is 4 bits; no wrap permitted (parameter range enforced).
- Async reset mid-access immediately clears `mem_we`/`mem_ce`.

Test Plan:
- RD_WAIT=1: write 0xDEADBEEF to memory model @0x40, raise `read_q` with `addr_in`=0x40 → `read_dn` one pulse at cycle 4, `data_out`=0xDEADBEEF, `addr_out`=0x40. Both are 0 the cycle after.
- WR_WAIT=2: `write_q`, addr 0x10, data 0x12345678 → `mem_we` high exactly 3 cycles, `write_dn` at cycle 5; memory readback gives 0x12345678.
- `read_q` and `write_q` both high in WAIT → write performed first, no `read_dn`. After both requests drop, a fresh read returns the written data.
- `rw_halt` pulsed during WRITE_SET_WE → `mem_we` low next cycle, no `write_dn`, state WAIT. `rw_halt` held in WAIT → request ignored until release.
- `rst_in` low during READ_DATA_GET → `mem_ce`/`mem_oe`/`read_dn`/`data_out` 0 immediately (asynchronously). After release, a new read completes normally.
- `read_q` held high 10 cycles → exactly one `read_dn` pulse and one memory access.
